// File: rtl/bus_sequencer.sv
// ============================================================================
// Module   : bus_sequencer
// Brief    : 16-tick memory-bus time-slot sequencer (SPI / video / CPU).
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_sequencer (
  input  logic       clk16_i,
  input  logic       reset_ni,
  input  logic       video_en_i,
  input  logic       col80_i,
  input  logic       cpu_halt_i,
  input  logic       spi_req_i,
  output logic       spi_ack_o,
  output logic       spi_en_o,
  output logic       vram0_en_o,
  output logic       vrom0_en_o,
  output logic       vram1_en_o,
  output logic       vrom1_en_o,
  output logic       cpu_en_o,
  output logic       setup_clk_o,
  output logic       strobe_clk_o,
  output logic       cclk_en_o,
  output logic [2:0] slot_o
);

  localparam logic [2:0] c_slot_spi   = 3'd0;
  localparam logic [2:0] c_slot_vram0 = 3'd1;
  localparam logic [2:0] c_slot_vrom0 = 3'd2;
  localparam logic [2:0] c_slot_vram1 = 3'd3;
  localparam logic [2:0] c_slot_vrom1 = 3'd4;
  localparam logic [2:0] c_slot_cpu   = 3'd7;
  localparam logic [3:0] c_count_rst  = 4'd15;
  localparam logic [3:0] c_count_ack  = 4'd2;
  localparam logic [3:0] c_count_cclk = 4'd15;

  logic [3:0] count_q, count_d;
  logic       vid_q, vid_d, col_q, col_d, halt_q, halt_d, req_q, req_d;
  logic [2:0] w_slot_d;
  logic       spi_en_d, vram0_en_d, vrom0_en_d, vram1_en_d, vrom1_en_d, cpu_en_d;
  logic       spi_ack_d, setup_d, strobe_d, cclk_d;

  // State register: tick counter, frame-start samples and registered outputs
  always_ff @(posedge clk16_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q      <= c_count_rst;
      vid_q        <= 1'b0;
      col_q        <= 1'b0;
      halt_q       <= 1'b0;
      req_q        <= 1'b0;
      spi_en_o     <= 1'b0;
      vram0_en_o   <= 1'b0;
      vrom0_en_o   <= 1'b0;
      vram1_en_o   <= 1'b0;
      vrom1_en_o   <= 1'b0;
      cpu_en_o     <= 1'b0;
      spi_ack_o    <= 1'b0;
      setup_clk_o  <= 1'b0;
      strobe_clk_o <= 1'b0;
      cclk_en_o    <= 1'b0;
      slot_o       <= c_slot_cpu;
    end else begin
      count_q      <= count_d;
      vid_q        <= vid_d;
      col_q        <= col_d;
      halt_q       <= halt_d;
      req_q        <= req_d;
      spi_en_o     <= spi_en_d;
      vram0_en_o   <= vram0_en_d;
      vrom0_en_o   <= vrom0_en_d;
      vram1_en_o   <= vram1_en_d;
      vrom1_en_o   <= vrom1_en_d;
      cpu_en_o     <= cpu_en_d;
      spi_ack_o    <= spi_ack_d;
      setup_clk_o  <= setup_d;
      strobe_clk_o <= strobe_d;
      cclk_en_o    <= cclk_d;
      slot_o       <= w_slot_d;
    end
  end

  // Next state: inputs are captured only on the edge that enters count 0
  always_comb begin
    count_d = count_q + 4'd1;
    vid_d   = vid_q;
    col_d   = col_q;
    halt_d  = halt_q;
    req_d   = req_q;
    if (count_d == 4'd0) begin
      vid_d  = video_en_i;
      col_d  = col80_i;
      halt_d = cpu_halt_i;
      req_d  = spi_req_i;
    end
  end

  // Output decode from the next count so outputs move together with count
  always_comb begin
    w_slot_d   = count_d[3:1];
    spi_en_d   = req_d && (w_slot_d == c_slot_spi);
    vram0_en_d = vid_d && (w_slot_d == c_slot_vram0);
    vrom0_en_d = vid_d && (w_slot_d == c_slot_vrom0);
    vram1_en_d = vid_d && col_d && (w_slot_d == c_slot_vram1);
    vrom1_en_d = vid_d && col_d && (w_slot_d == c_slot_vrom1);
    cpu_en_d   = !halt_d && (w_slot_d == c_slot_cpu);
    spi_ack_d  = req_d && (count_d == c_count_ack);
    setup_d    = !count_d[0];
    strobe_d   = count_d[0];
    cclk_d     = (count_d == c_count_cclk);
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_sequencer.sv
// ============================================================================
// Module   : tb_bus_sequencer
// Brief    : Randomized self-checking bench for bus_sequencer with a frame model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset_ni = 1'b1;
  logic       video_en = 1'b0, col80 = 1'b0, cpu_halt = 1'b0, spi_req = 1'b0;
  logic       spi_ack, spi_en, vram0_en, vrom0_en, vram1_en, vrom1_en, cpu_en;
  logic       setup_clk, strobe_clk, cclk_en;
  logic [2:0] slot;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bus_sequencer dut (
    .clk16_i(clk), .reset_ni(reset_ni), .video_en_i(video_en), .col80_i(col80),
    .cpu_halt_i(cpu_halt), .spi_req_i(spi_req), .spi_ack_o(spi_ack), .spi_en_o(spi_en),
    .vram0_en_o(vram0_en), .vrom0_en_o(vrom0_en), .vram1_en_o(vram1_en),
    .vrom1_en_o(vrom1_en), .cpu_en_o(cpu_en), .setup_clk_o(setup_clk),
    .strobe_clk_o(strobe_clk), .cclk_en_o(cclk_en), .slot_o(slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: tick index within the frame plus the frame's sampled controls
  int m_tick = 15;
  bit m_in_reset = 1'b1;
  bit f_vid = 0, f_col = 0, f_halt = 0, f_req = 0;

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      m_tick = 15; m_in_reset = 1;
      f_vid = 0; f_col = 0; f_halt = 0; f_req = 0;
    end else begin
      m_tick = (m_tick + 1) % 16;
      m_in_reset = 0;
      if (m_tick == 0) begin
        f_vid = video_en; f_col = col80; f_halt = cpu_halt; f_req = spi_req;
      end
    end
  end

  // Owner of each slot under the current frame's controls: {spi,vram0,vrom0,vram1,vrom1,cpu}
  function automatic logic [5:0] owner_vec(input int s);
    logic [5:0] v = 6'b0;
    case (s)
      0: v[5] = f_req;
      1: v[4] = f_vid;
      2: v[3] = f_vid;
      3: v[2] = f_vid && f_col;
      4: v[1] = f_vid && f_col;
      7: v[0] = !f_halt;
      default: v = 6'b0;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [5:0] act_en;
      act_en = {spi_en, vram0_en, vrom0_en, vram1_en, vrom1_en, cpu_en};
      check("onehot", 32'($countones(act_en) <= 1), 32'd1);
      if (m_in_reset) begin
        check("rst_en", {26'b0, act_en}, 32'd0);
        check("rst_misc", {28'b0, setup_clk, strobe_clk, cclk_en, spi_ack}, 32'd0);
        check("rst_slot", {29'b0, slot}, 32'd7);
      end else begin
        check("enables", {26'b0, act_en}, {26'b0, owner_vec(m_tick / 2)});
        check("slot", {29'b0, slot}, 32'(m_tick / 2));
        check("setup", {31'b0, setup_clk}, 32'(m_tick % 2 == 0));
        check("strobe", {31'b0, strobe_clk}, 32'(m_tick % 2 == 1));
        check("cclk", {31'b0, cclk_en}, 32'(m_tick == 15));
        check("ack", {31'b0, spi_ack}, 32'(f_req && m_tick == 2));
      end
    end
  end

  // Hand-written expectations for the first frame with video on, 80 columns, no SPI
  function automatic logic [6:0] frame0_vec(input int k);
    case (k)
      2, 3:   return 7'b0100000;
      4, 5:   return 7'b0010000;
      6, 7:   return 7'b0001000;
      8, 9:   return 7'b0000100;
      14:     return 7'b0000010;
      15:     return 7'b0000011;
      default: return 7'b0000000;
    endcase
  endfunction

  int acks_seen = 0;

  initial begin
    #1 reset_ni = 1'b0;
    #1 chk_en = 1'b1;
    video_en = 1'b1; col80 = 1'b1;
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;

    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (spi_ack) acks_seen++;
        if (f == 0) begin
          check("lit_f0_vec", {25'b0, spi_en, vram0_en, vrom0_en, vram1_en, vrom1_en, cpu_en, cclk_en},
                {25'b0, frame0_vec(k)});
          check("lit_f0_slot", {29'b0, slot}, 32'(k / 2));
        end
        if (f == 1 && k == 3) spi_req = 1'b1;
        if (f == 1 && k == 5) col80 = 1'b0;
        if (f == 1 && k == 6) check("lit_col80_late", {31'b0, vram1_en}, 32'd1);
        if (f == 2 && k == 0) check("lit_spi_grant", {31'b0, spi_en}, 32'd1);
        if (f == 2 && k == 2) begin
          check("lit_spi_ack", {31'b0, spi_ack}, 32'd1);
          spi_req = 1'b0;
        end
        if (f == 2 && k == 3) check("lit_ack_pulse", {31'b0, spi_ack}, 32'd0);
        if (f == 2 && k == 6) check("lit_col80_off", {31'b0, vram1_en}, 32'd0);
        if (f == 3 && k == 0) check("lit_no_regrant", {31'b0, spi_en}, 32'd0);
      end
    end
    check("lit_one_grant", 32'(acks_seen), 32'd1);

    // Directed: reset during an SPI grant, then clean restart
    spi_req = 1'b1;
    @(negedge clk);
    while (slot != 3'd0 || setup_clk != 1'b0) @(negedge clk);
    #2 reset_ni = 1'b0;
    #1 check("lit_async_rst", {26'b0, spi_en, vram0_en, vrom0_en, vram1_en, vrom1_en, cpu_en}, 32'd0);
    check("lit_async_slot", {29'b0, slot}, 32'd7);
    @(negedge clk);
    check("lit_no_ack_rst", {31'b0, spi_ack}, 32'd0);
    reset_ni = 1'b1;
    @(negedge clk);
    check("lit_restart", {28'b0, slot, setup_clk}, {28'b0, 3'd0, 1'b1});
    spi_req = 1'b0;

    // Randomized traffic with occasional mid-frame resets
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if ($urandom_range(31) == 0) video_en = ~video_en;
      if ($urandom_range(15) == 0) col80 = ~col80;
      if ($urandom_range(15) == 0) cpu_halt = ~cpu_halt;
      if (!spi_req) begin
        if ($urandom_range(7) == 0) spi_req = 1'b1;
      end else if (spi_ack && $urandom_range(1) == 0) begin
        spi_req = 1'b0;
      end
      if ($urandom_range(399) == 0) begin
        #3 reset_ni = 1'b0;
        #1 check("rnd_async_rst", {26'b0, spi_en, vram0_en, vrom0_en, vram1_en, vrom1_en, cpu_en}, 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_sequencer.md
# bus_sequencer

Generates the fixed 16-tick time-slot schedule that shares the memory bus between the CPU, the video fetch path (VRAM/VROM even/odd character fetches) and an external SPI bus master. It emits the per-slot enables, the setup/strobe phase clocks and the 1 MHz character-clock enable consumed by the video block and CRTC, and arbitrates the SPI master's access via a req/ack handshake. It sits at the top of the timing tree, clocked directly from the 16 MHz system clock.

## Interface
Parameters: none (frame length fixed at 16 ticks).
- clk16_i  in  1  16 MHz system clock; all logic on rising edge
- reset_ni  in  1  asynchronous active-low reset
- video_en_i  in  1  enables video fetch slots; sampled at frame start
- col80_i  in  1  1 = 80-column (fetch even+odd), 0 = 40-column (even only); sampled at frame start
- cpu_halt_i  in  1  suppresses the CPU slot; sampled at frame start
- spi_req_i  in  1  SPI master bus request, level, held until ack
- spi_ack_o  out  1  one-tick pulse: SPI access complete
- spi_en_o  out  1  SPI master owns bus (slot 0)
- vram0_en_o, vrom0_en_o, vram1_en_o, vrom1_en_o  out  1 each  video fetch slot enables (slots 1-4)
- cpu_en_o  out  1  CPU owns bus (slot 7)
- setup_clk_o  out  1  high during phase 0 of every slot
- strobe_clk_o  out  1  high during phase 1 of every slot; consumers latch on its falling edge
- cclk_en_o  out  1  character-clock enable, one tick per frame
- slot_o  out  3  current slot number (debug/verification)

## Operation
- 4-bit tick counter `count`; slot = count[3:1], phase = count[0]; increments every clk16_i, wraps 15->0.
- Slot map: 0 SPI, 1 VRAM0, 2 VROM0, 3 VRAM1, 4 VROM1, 5 idle, 6 idle, 7 CPU.
- Frame-start sampling: video_en_i, col80_i, cpu_halt_i and spi_req_i are registered on the edge that enters count 0 and held constant for the whole frame. A frame is never partially video-enabled.
- Slot 0: spi_en_o high (counts 0-1) only if spi_req_i was sampled high; otherwise idle. A request arriving after the sampling edge waits for the next frame.
- Slots 1-2: enables high only if video_en sampled high. Slots 3-4: only if video_en and col80 both sampled high.
- Slot 7: cpu_en_o high unless cpu_halt sampled high.
- setup_clk_o/strobe_clk_o toggle every tick regardless of ownership (idle slots still clock).
- cclk_en_o high at count 15 only (coincides with CPU slot phase 1), independent of video_en_i.
- spi_ack_o pulses at count 2 in any frame where spi_en_o was asserted; requester must drop spi_req_i before the next frame start or is granted again.
- Outputs mutually exclusive: at most one of spi/vram0/vrom0/vram1/vrom1/cpu enables is high in any tick.

## Timing
- All outputs registered, decoded from count's next value, so they change coincident with count.
- Reset (async assert): count = 15, all enables, setup_clk_o, strobe_clk_o, cclk_en_o, spi_ack_o = 0, slot_o = 7, sampled flags = 0.
- Reset release: first rising edge enters count 0: setup_clk_o = 1, slot_o = 0, spi_en_o per spi_req_i at that edge.
- Each slot enable spans exactly 2 ticks (125 ns); frame = 16 ticks (1 µs).
- SPI latency: req sampled high at frame-start edge -> spi_en_o same edge -> spi_ack_o 2 ticks later; worst case req-to-ack 18 ticks.
- Reset asserted mid-frame: outputs drop immediately (async); any in-flight SPI access is abandoned without ack; requester must re-request.
- spi_req_i may be asynchronous to frame; only the frame-start sample matters (no glitch on spi_en_o).

## Test plan
- Reset release, video_en=1, col80=1, no req -> count 0..15 shows slot_o 0..7 in pairs; vram0/vrom0/vram1/vrom1 high at counts 2-3/4-5/6-7/8-9; cpu_en_o at 14-15; cclk_en_o only at 15; spi_en_o never.
- col80=0 -> vram1/vrom1 stay 0; vram0/vrom0 unchanged. Toggle col80 at count 5 -> effect only from next frame.
- spi_req_i raised at count 3 -> spi_en_o at counts 0-1 of next frame, spi_ack_o single pulse at count 2; hold req through ack then drop -> exactly one grant.
- spi_req_i raised exactly at frame-start edge -> granted in that frame; req held 3 frames -> 3 grants, 3 acks.
- cpu_halt_i=1 sampled -> cpu_en_o low in slot 7, cclk_en_o still pulses at count 15.
- Assert reset_ni low at count 1 during SPI grant -> all outputs 0 asynchronously, no spi_ack_o; release -> clean restart at count 0; check one-hot exclusivity throughout.
